// File: rtl/irq_controller_pkg.sv
// Shared register map, TCON bit positions and FSM state encoding for the interrupt controller.
package irq_controller_pkg;

    localparam logic [7:0] OFF_TH     = 8'h00;
    localparam logic [7:0] OFF_TL     = 8'h04;
    localparam logic [7:0] OFF_TCON   = 8'h08;
    localparam logic [7:0] OFF_IEN    = 8'h20;
    localparam logic [7:0] OFF_IPEND  = 8'h24;
    localparam logic [7:0] OFF_ICAUSE = 8'h28;
    localparam logic [7:0] OFF_ISET   = 8'h2C;

    localparam int TCON_RUN = 0;
    localparam int TCON_IE  = 1;
    localparam int TCON_W   = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        SVC  = 2'd2
    } irqc_state_e;

endpackage

// File: rtl/irq_timer.sv
// Purpose: free-running reload timer (TH/TL/TCON) feeding interrupt source 0.
// Latency: TL at all-ones reloads from TH on the next edge; tick is combinational with that edge.
// Backpressure: none; a CPU write to TL overrides the count in the same cycle.
module irq_timer
    import irq_controller_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [7:0]        addr,
    input  logic [31:0]       wdata,
    output logic              tick,
    output logic [31:0]       th,
    output logic [31:0]       tl,
    output logic [TCON_W-1:0] tcon
);

    logic wrap;

    assign wrap = tcon[TCON_RUN] && (&tl);
    assign tick = wrap && tcon[TCON_IE];

    always_ff @(posedge clk) begin
        if (!reset) begin
            th   <= '0;
            tl   <= '0;
            tcon <= '0;
        end else begin
            if (wr_en && addr == OFF_TH)
                th <= wdata;
            if (wr_en && addr == OFF_TCON)
                tcon <= wdata[TCON_W-1:0];
            if (wr_en && addr == OFF_TL)
                tl <= wdata;
            else if (tcon[TCON_RUN])
                tl <= wrap ? th : tl + 32'd1;
        end
    end

endmodule

// File: rtl/irq_controller.sv
// Purpose: pending/enable/priority interrupt controller with user-mode IRQ handshake; timer under IRQC_TIMER_EN.
// Latency: pulse at edge k sets IPEND; irq rises after edge k+1; register reads are combinational.
// Backpressure: none; events accumulate in IPEND while a handler runs or kernel mode holds requests off.
module irq_controller
    import irq_controller_pkg::*;
#(
    parameter int NUM_SRC = 4,
    parameter int ID_W    = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               sel,
    input  logic [7:0]         addr,
    input  logic [31:0]        wdata,
    input  logic               we,
    input  logic               rd,
    output logic [31:0]        rdata,
    input  logic [NUM_SRC-1:0] src_pulse,
    input  logic               kernel,
    output logic               irq,
    output logic [ID_W-1:0]    irq_id
);

    logic               wr_en;
    logic [NUM_SRC-1:0] pend;
    logic [NUM_SRC-1:0] ien;
    logic [NUM_SRC-1:0] act;
    logic [NUM_SRC-1:0] src_eff;
    logic [NUM_SRC-1:0] w1c;
    logic [NUM_SRC-1:0] w1s;
    logic [ID_W-1:0]    best;
    logic               any_act;
    logic               unused_wdata;
    irqc_state_e        state;

    assign wr_en        = sel && we;
    assign unused_wdata = ^wdata[31:NUM_SRC];

`ifdef IRQC_TIMER_EN
    logic              timer_tick;
    logic [31:0]       timer_th;
    logic [31:0]       timer_tl;
    logic [TCON_W-1:0] timer_tcon;

    irq_timer u_timer (
        .clk   (clk),
        .reset (reset),
        .wr_en (wr_en),
        .addr  (addr),
        .wdata (wdata),
        .tick  (timer_tick),
        .th    (timer_th),
        .tl    (timer_tl),
        .tcon  (timer_tcon)
    );

    assign src_eff = src_pulse | {{(NUM_SRC-1){1'b0}}, timer_tick};
`else
    assign src_eff = src_pulse;
`endif

    assign w1c     = (wr_en && addr == OFF_IPEND) ? wdata[NUM_SRC-1:0] : '0;
    assign w1s     = (wr_en && addr == OFF_ISET)  ? wdata[NUM_SRC-1:0] : '0;
    assign act     = pend & ien;
    assign any_act = |act;

    // Scan from the top so the lowest set index is the one left in best.
    always_comb begin
        best = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (act[i])
                best = ID_W'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pend <= '0;
            ien  <= '0;
        end else begin
            if (wr_en && addr == OFF_IEN)
                ien <= wdata[NUM_SRC-1:0];
            pend <= (pend & ~w1c) | w1s | src_eff;
        end
    end

    // irq_id stays frozen through SVC so software can see what it is servicing.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= IDLE;
            irq    <= 1'b0;
            irq_id <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_act && !kernel) begin
                        state  <= REQ;
                        irq    <= 1'b1;
                        irq_id <= best;
                    end
                end
                REQ: begin
                    if (!any_act) begin
                        state <= IDLE;
                        irq   <= 1'b0;
                    end else if (kernel) begin
                        state <= SVC;
                        irq   <= 1'b0;
                    end else begin
                        irq_id <= best;
                    end
                end
                SVC: begin
                    if (!kernel)
                        state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    irq   <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        rdata = '0;
        if (sel && rd) begin
            case (addr)
                OFF_IEN:    rdata = {{(32-NUM_SRC){1'b0}}, ien};
                OFF_IPEND:  rdata = {{(32-NUM_SRC){1'b0}}, pend};
                OFF_ICAUSE: rdata = {{(32-ID_W-1){1'b0}}, best, any_act};
`ifdef IRQC_TIMER_EN
                OFF_TH:     rdata = timer_th;
                OFF_TL:     rdata = timer_tl;
                OFF_TCON:   rdata = {{(32-TCON_W){1'b0}}, timer_tcon};
`endif
                default:    rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_irq_controller.sv
// Bench for irq_controller: register vector table, directed handshake/timer sequences, randomized run vs a rule-level model.
module tb_irq_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic        sel;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic        we;
    logic        rd;
    logic [31:0] rdata;
    logic [3:0]  src_pulse;
    logic        kernel;
    logic        irq;
    logic [1:0]  irq_id;

    int checks = 0;
    int errors = 0;

    // Reference model state, expressed as the spec's rules.
    logic [3:0] m_pend, m_ien;
    bit         m_irq, m_svc;
    int         m_id;

    typedef struct {
        logic        sel;
        logic        we;
        logic        rd;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[15];

    irq_controller dut (
        .clk       (clk),
        .reset     (reset),
        .sel       (sel),
        .addr      (addr),
        .wdata     (wdata),
        .we        (we),
        .rd        (rd),
        .rdata     (rdata),
        .src_pulse (src_pulse),
        .kernel    (kernel),
        .irq       (irq),
        .irq_id    (irq_id)
    );

    always #5 clk = ~clk;

    task automatic check(input logic [31:0] got, input logic [31:0] exp, input string name);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        sel = 1'b1; we = 1'b1; addr = a; wdata = d;
        step(1);
        sel = 1'b0; we = 1'b0; wdata = '0;
    endtask

    task automatic rd_chk(input logic [7:0] a, input logic [31:0] exp, input string name);
        sel = 1'b1; rd = 1'b1; addr = a;
        #1;
        check(rdata, exp, name);
        sel = 1'b0; rd = 1'b0;
    endtask

    task automatic chk_irq(input logic exp_irq, input int exp_id, input string name);
        check({31'b0, irq}, {31'b0, exp_irq}, {name, "_irq"});
        if (exp_id >= 0)
            check({30'b0, irq_id}, exp_id, {name, "_id"});
    endtask

    task automatic reset_dut();
        reset = 1'b0;
        step(2);
        reset = 1'b1;
        m_pend = '0; m_ien = '0; m_irq = 0; m_svc = 0; m_id = 0;
    endtask

    // Isolate the lowest set bit arithmetically, then take its log2.
    function automatic int lowest(input logic [3:0] a);
        int v;
        v = int'(a);
        return $clog2(v & -v);
    endfunction

    function automatic logic [31:0] model_read(input logic [7:0] a);
        logic [3:0] act;
        act = m_pend & m_ien;
        case (a)
            8'h20:   return {28'b0, m_ien};
            8'h24:   return {28'b0, m_pend};
            8'h28:   return (act != 0) ? 32'(lowest(act) * 2 + 1) : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_edge();
        logic [3:0] act, clr, set;
        act = m_pend & m_ien;
        if (m_svc) begin
            if (!kernel) m_svc = 0;
        end else if (m_irq) begin
            if (act == 0) m_irq = 0;
            else if (kernel) begin m_irq = 0; m_svc = 1; end
            else m_id = lowest(act);
        end else if (act != 0 && !kernel) begin
            m_irq = 1;
            m_id  = lowest(act);
        end
        clr = (sel && we && addr == 8'h24) ? wdata[3:0] : 4'h0;
        set = (sel && we && addr == 8'h2C) ? wdata[3:0] : 4'h0;
        m_pend = (m_pend & ~clr) | set | src_pulse;
        if (sel && we && addr == 8'h20) m_ien = wdata[3:0];
    endtask

    initial begin
        logic [7:0] rd_addrs[6];
        rd_addrs = '{8'h20, 8'h24, 8'h28, 8'h2C, 8'h30, 8'h08};

        vecs[0]  = '{1'b1, 1'b1, 1'b0, 8'h20, 32'hFFFF_FFFF, 32'h0};
        vecs[1]  = '{1'b1, 1'b0, 1'b1, 8'h20, 32'h0,         32'hF};
        vecs[2]  = '{1'b1, 1'b1, 1'b0, 8'h28, 32'h7,         32'h0};
        vecs[3]  = '{1'b1, 1'b0, 1'b1, 8'h28, 32'h0,         32'h0};
        vecs[4]  = '{1'b1, 1'b1, 1'b0, 8'h2C, 32'h4,         32'h0};
        vecs[5]  = '{1'b1, 1'b0, 1'b1, 8'h24, 32'h0,         32'h4};
        vecs[6]  = '{1'b1, 1'b0, 1'b1, 8'h28, 32'h0,         32'h5};
        vecs[7]  = '{1'b1, 1'b1, 1'b0, 8'h30, 32'hFF,        32'h0};
        vecs[8]  = '{1'b1, 1'b0, 1'b1, 8'h30, 32'h0,         32'h0};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 8'h24, 32'h0,         32'h0};
        vecs[10] = '{1'b1, 1'b0, 1'b1, 8'h2C, 32'h0,         32'h0};
        vecs[11] = '{1'b1, 1'b1, 1'b0, 8'h24, 32'h4,         32'h0};
        vecs[12] = '{1'b1, 1'b0, 1'b1, 8'h24, 32'h0,         32'h0};
        vecs[13] = '{1'b1, 1'b1, 1'b1, 8'h20, 32'h0,         32'hF};
        vecs[14] = '{1'b1, 1'b0, 1'b1, 8'h20, 32'h0,         32'h0};

        reset = 1'b0; sel = 1'b0; addr = '0; wdata = '0; we = 1'b0; rd = 1'b0;
        src_pulse = '0; kernel = 1'b1;
        step(2);
        chk_irq(1'b0, 0, "por");
        reset = 1'b1;

        // Register access table; kernel held high so no request interferes.
        for (int i = 0; i < 15; i++) begin
            sel = vecs[i].sel; we = vecs[i].we; rd = vecs[i].rd;
            addr = vecs[i].addr; wdata = vecs[i].wdata;
            #1;
            check(rdata, vecs[i].exp, $sformatf("vec%0d", i));
            step(1);
            sel = 1'b0; we = 1'b0; rd = 1'b0; wdata = '0;
        end

        // 1: reset in the middle of a request
        wr(8'h20, 32'h2);
        wr(8'h2C, 32'h2);
        kernel = 1'b0;
        step(1);
        chk_irq(1'b1, 1, "t1_req");
        reset = 1'b0;
        step(2);
        chk_irq(1'b0, 0, "t1_rst");
        reset = 1'b1;
        rd_chk(8'h24, 32'h0, "t1_ipend");
        rd_chk(8'h20, 32'h0, "t1_ien");

        // 2: latency from pulse to irq
        wr(8'h20, 32'h2);
        src_pulse = 4'h2;
        step(1);
        src_pulse = 4'h0;
        rd_chk(8'h24, 32'h2, "t2_ipend");
        chk_irq(1'b0, -1, "t2_k");
        step(1);
        chk_irq(1'b1, 1, "t2_k1");
        wr(8'h24, 32'h2);
        step(1);
        chk_irq(1'b0, -1, "t2_clr");

        // 3: priority and handler handshake
        wr(8'h20, 32'hF);
        src_pulse = 4'h6;
        step(1);
        src_pulse = 4'h0;
        step(1);
        chk_irq(1'b1, 1, "t3_prio");
        kernel = 1'b1;
        step(1);
        chk_irq(1'b0, 1, "t3_svc");
        wr(8'h24, 32'h2);
        rd_chk(8'h28, 32'h5, "t3_icause");
        kernel = 1'b0;
        step(1);
        chk_irq(1'b0, -1, "t3_exit");
        step(1);
        chk_irq(1'b1, 2, "t3_next");
        wr(8'h24, 32'h4);
        step(1);
        chk_irq(1'b0, -1, "t3_clr");

        // 4: hold-off in kernel mode, then withdraw
        kernel = 1'b1;
        src_pulse = 4'h8;
        step(1);
        src_pulse = 4'h0;
        step(3);
        chk_irq(1'b0, -1, "t4_hold");
        rd_chk(8'h24, 32'h8, "t4_ipend");
        kernel = 1'b0;
        step(1);
        chk_irq(1'b1, 3, "t4_req");
        wr(8'h24, 32'h8);
        step(1);
        chk_irq(1'b0, -1, "t4_wd");
        step(1);
        chk_irq(1'b0, -1, "t4_idle");

        // 5: set beats clear in the same cycle; ISET
        kernel = 1'b1;
        sel = 1'b1; we = 1'b1; addr = 8'h24; wdata = 32'h4; src_pulse = 4'h4;
        step(1);
        sel = 1'b0; we = 1'b0; src_pulse = 4'h0;
        rd_chk(8'h24, 32'h4, "t5_collide");
        wr(8'h2C, 32'h8);
        rd_chk(8'h24, 32'hC, "t5_iset");
        wr(8'h24, 32'hF);
        rd_chk(8'h24, 32'h0, "t5_w1c");

        // Randomized run against the model
        kernel = 1'b0;
        reset_dut();
        for (int c = 0; c < 400; c++) begin
            int op;
            logic [7:0] ra;
            ra = 8'h0;
            src_pulse = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            if ($urandom_range(0, 5) == 0) kernel = ~kernel;
            sel = 1'b0; we = 1'b0; rd = 1'b0;
            op = $urandom_range(0, 9);
            case (op)
                0: begin sel = 1'b1; we = 1'b1; addr = 8'h20; wdata = $urandom; end
                1: begin sel = 1'b1; we = 1'b1; addr = 8'h24; wdata = $urandom; end
                2: begin sel = 1'b1; we = 1'b1; addr = 8'h2C; wdata = $urandom & $urandom; end
                3, 4, 5: begin
                    ra = rd_addrs[$urandom_range(0, 5)];
                    sel = 1'b1; rd = 1'b1; addr = ra;
                end
                default: ;
            endcase
            #1;
            if (rd) check(rdata, model_read(ra), $sformatf("rnd_rd%0d", c));
            @(posedge clk);
            model_edge();
            #1;
            check({31'b0, irq}, {31'b0, m_irq}, $sformatf("rnd_irq%0d", c));
            check({30'b0, irq_id}, m_id, $sformatf("rnd_id%0d", c));
        end
        sel = 1'b0; we = 1'b0; rd = 1'b0; src_pulse = 4'h0;

        // 6: timer
        kernel = 1'b1;
        reset_dut();
`ifdef IRQC_TIMER_EN
        wr(8'h00, 32'hFFFF_FFFD);
        wr(8'h04, 32'hFFFF_FFFD);
        wr(8'h20, 32'h1);
        wr(8'h08, 32'h3);
        rd_chk(8'h04, 32'hFFFF_FFFD, "t6_tl0");
        rd_chk(8'h24, 32'h0, "t6_pend0");
        step(1);
        rd_chk(8'h04, 32'hFFFF_FFFE, "t6_tl1");
        step(1);
        rd_chk(8'h04, 32'hFFFF_FFFF, "t6_tl2");
        rd_chk(8'h24, 32'h0, "t6_pend2");
        step(1);
        rd_chk(8'h04, 32'hFFFF_FFFD, "t6_reload");
        rd_chk(8'h24, 32'h1, "t6_pulse1");
        rd_chk(8'h08, 32'h3, "t6_tcon");
        rd_chk(8'h00, 32'hFFFF_FFFD, "t6_th");
        wr(8'h24, 32'h1);
        rd_chk(8'h24, 32'h0, "t6_clr");
        rd_chk(8'h04, 32'hFFFF_FFFE, "t6_tl4");
        step(1);
        rd_chk(8'h24, 32'h0, "t6_pend5");
        step(1);
        rd_chk(8'h24, 32'h1, "t6_pulse2");
        kernel = 1'b0;
        step(1);
        chk_irq(1'b1, 0, "t6_irq");
        wr(8'h04, 32'h10);
        rd_chk(8'h04, 32'h10, "t6_tl_wr");
        step(1);
        rd_chk(8'h04, 32'h11, "t6_tl_cnt");
`else
        wr(8'h00, 32'hFFFF_FFFD);
        wr(8'h04, 32'hFFFF_FFFD);
        wr(8'h08, 32'h3);
        wr(8'h20, 32'h1);
        kernel = 1'b0;
        step(8);
        rd_chk(8'h00, 32'h0, "t6_th");
        rd_chk(8'h04, 32'h0, "t6_tl");
        rd_chk(8'h08, 32'h0, "t6_tcon");
        rd_chk(8'h24, 32'h0, "t6_pend");
        chk_irq(1'b0, -1, "t6_noirq");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
